// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, AXI responses,
// FSM encodings and address decode helpers.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } reg_sel_t;

  typedef struct packed {
    reg_sel_t   sel;
    logic [2:0] hart;
  } reg_dec_t;

  // Harts beyond the configured count decode as holes so they answer SLVERR.
  function automatic reg_dec_t decode(input logic [15:0] off, input int harts);
    reg_dec_t d;
    d.sel  = REG_NONE;
    d.hart = '0;
    if (off == MTIME_LO) begin
      d.sel = REG_MTIME_LO;
    end else if (off == MTIME_HI) begin
      d.sel = REG_MTIME_HI;
    end else if (off[15:5] == MSIP_BASE[15:5] && off[1:0] == 2'b00 &&
                 {29'd0, off[4:2]} < 32'(harts)) begin
      d.sel  = REG_MSIP;
      d.hart = off[4:2];
    end else if (off[15:6] == MTIMECMP_BASE[15:6] && off[1:0] == 2'b00 &&
                 {29'd0, off[5:3]} < 32'(harts)) begin
      d.sel  = off[2] ? REG_CMP_HI : REG_CMP_LO;
      d.hart = off[5:3];
    end
    return d;
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaler plus free-running 64-bit mtime; a bus write replaces the addressed half
// byte-wise, suppresses that cycle's increment and restarts the prescaler.
module clint_mtime_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime
);
  import clint_pkg::*;

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (wr_en) begin
      presc <= '0;
      if (wr_hi) mtime[63:32] <= merge_strb(mtime[63:32], wr_data, wr_strb);
      else       mtime[31:0]  <= merge_strb(mtime[31:0], wr_data, wr_strb);
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint_axil_timer.sv
// Core-local interruptor with an AXI4-Lite slave: per-hart mtimecmp/msip, registered
// mtip/msip outputs, and a coherent 64-bit mtime read via a hi-word shadow.
//
//   state     | meaning
//   R_IDLE    | arready high, waiting for a read address
//   R_RESP    | read data held on R channel until rready
//   W_COLLECT | accepting AW and W independently; commits once both are held
//   W_RESP    | write response held on B channel until bready
module clint_axil_timer #(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV  = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  output logic [1:0]           s_axi_bresp,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);
  import clint_pkg::*;

  rd_state_t                   rd_state;
  wr_state_t                   wr_state;
  logic [63:0]                 mtime;
  logic [NUM_HARTS-1:0][63:0]  cmp_all;
  logic [15:0]                 awaddr_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  wstrb_q;
  logic [31:0]                 shadow_hi;
  reg_dec_t                    rd_dec;
  reg_dec_t                    wr_dec;
  logic                        wr_fire;
  logic                        wr_apply;
  logic [31:0]                 rd_val;
  logic                        rd_ok;

  assign rd_dec   = decode(s_axi_araddr[15:0], NUM_HARTS);
  assign wr_dec   = decode(awaddr_q, NUM_HARTS);
  assign wr_fire  = (wr_state == W_COLLECT) && !s_axi_awready && !s_axi_wready;
  assign wr_apply = wr_fire && (|wstrb_q);

  if (ADDR_W > 16) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr[ADDR_W-1:16], s_axi_araddr[ADDR_W-1:16]};
  end

  clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_apply && (wr_dec.sel == REG_MTIME_LO || wr_dec.sel == REG_MTIME_HI)),
    .wr_hi   (wr_dec.sel == REG_MTIME_HI),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q),
    .mtime   (mtime)
  );

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic [63:0] cmp;
    logic        msip_q;
    logic        mtip_q;
    logic        hit;

    assign hit = wr_apply && (wr_dec.hart == 3'(h));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp    <= '1;
        msip_q <= 1'b0;
        mtip_q <= 1'b0;
      end else begin
        if (hit && wr_dec.sel == REG_CMP_LO) cmp[31:0]  <= merge_strb(cmp[31:0], wdata_q, wstrb_q);
        if (hit && wr_dec.sel == REG_CMP_HI) cmp[63:32] <= merge_strb(cmp[63:32], wdata_q, wstrb_q);
        if (hit && wr_dec.sel == REG_MSIP && wstrb_q[0]) msip_q <= wdata_q[0];
        mtip_q <= (mtime >= cmp);
      end
    end

    assign cmp_all[h] = cmp;
    assign msip[h]    = msip_q;
    assign mtip[h]    = mtip_q;
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (rd_dec.sel)
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = shadow_hi;
      REG_MSIP, REG_CMP_LO, REG_CMP_HI: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (rd_dec.hart == 3'(h)) begin
            if (rd_dec.sel == REG_MSIP)        rd_val = {31'd0, msip[h]};
            else if (rd_dec.sel == REG_CMP_LO) rd_val = cmp_all[h][31:0];
            else                               rd_val = cmp_all[h][63:32];
          end
        end
      end
      default: rd_ok = 1'b0;
    endcase
  end

  // Reading the low word snapshots the high word so a lo/hi pair is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      shadow_hi     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rdata   <= rd_val;
            s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            rd_state      <= R_RESP;
            if (rd_dec.sel == REG_MTIME_LO) shadow_hi <= mtime[63:32];
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state      <= W_COLLECT;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (wr_state)
        W_COLLECT: begin
          if (s_axi_awvalid && s_axi_awready) begin
            awaddr_q      <= s_axi_awaddr[15:0];
            s_axi_awready <= 1'b0;
          end
          if (s_axi_wvalid && s_axi_wready) begin
            wdata_q      <= s_axi_wdata;
            wstrb_q      <= s_axi_wstrb;
            s_axi_wready <= 1'b0;
          end
          if (wr_fire) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (wr_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            wr_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_COLLECT;
          end
        end
        default: wr_state <= W_COLLECT;
      endcase
    end
  end

endmodule
